// File: rtl/apb_rr_master_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
// Shared definitions for the round-robin APB master arbiter:
//   - default parameter values (requester count, bus widths, timeout)
//   - FSM state encoding
//   - clog2 helper used to size the round-robin pointer and wait counter
// -----------------------------------------------------------------------------
package apb_arb_pkg;

  localparam int DEF_NREQ    = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Width of an index register that must exist even for a single item.
  function automatic int idx_w(input int value);
    return (value > 1) ? clog2(value) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_master_arbiter_if.sv
// -----------------------------------------------------------------------------
// apb_rr_master_arbiter_if
// APB bus bundle between the arbiter (master side) and the APB slave.
//   psel_o    master -> slave  select
//   penable_o master -> slave  enable (ACCESS phase)
//   paddr_o   master -> slave  address
//   pwrite_o  master -> slave  direction, 1 = write
//   pwdata_o  master -> slave  write data
//   prdata_i  slave  -> master read data
//   pready_i  slave  -> master transfer complete
// -----------------------------------------------------------------------------
interface apb_rr_master_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              psel_o;
  logic              penable_o;
  logic [ADDR_W-1:0] paddr_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;

  modport master (
    output psel_o,
    output penable_o,
    output paddr_o,
    output pwrite_o,
    output pwdata_o,
    input  prdata_i,
    input  pready_i
  );

  modport slave (
    input  psel_o,
    input  penable_o,
    input  paddr_o,
    input  pwrite_o,
    input  pwdata_o,
    output prdata_i,
    output pready_i
  );

endinterface

// File: rtl/apb_rr_master_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant logic. Searches the request vector
// upward starting at the pointer position, wrapping from NREQ-1 to 0, and
// returns the first set bit.
//   i_req    [NREQ-1:0]   request vector
//   i_ptr    [PTR_W-1:0]  highest-priority requester index
//   o_grant  [NREQ-1:0]   one-hot grant (zero when no request)
//   o_idx    [PTR_W-1:0]  index of the granted requester
//   o_any    1            at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int PTR_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  int w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      // Candidate requester for this search step, rotated by the pointer.
      w_k = int'(i_ptr) + i;
      if (w_k >= NREQ) begin
        w_k = w_k - NREQ;
      end
      if (!o_any && i_req[w_k]) begin
        o_any        = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx        = PTR_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_master_arbiter
// Shares one APB master port between NREQ local requesters. A round-robin
// arbiter picks a requester in IDLE; the transfer then runs through SETUP and
// ACCESS, waiting for pready_i or aborting after TIMEOUT ACCESS cycles. The
// result is returned to the requester that issued it as a one-cycle pulse.
//
// Ports:
//   pclk, preset   clock; synchronous active-high reset
//   req_valid_i    per-requester request pending
//   req_ready_o    one-hot accept strobe (combinational, IDLE only)
//   req_write_i    per-requester direction, 1 = write
//   req_addr_i     packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   req_wdata_i    packed write data, same packing
//   rsp_valid_o    one-hot completion pulse to the owning requester
//   rsp_rdata_o    read data (0 for writes and timeouts)
//   rsp_err_o      timeout flag, qualified by rsp_valid_o
//   apb            APB master modport
// -----------------------------------------------------------------------------
module apb_rr_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ-1:0]          req_write_i,
  input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NREQ*DATA_W-1:0]   req_wdata_i,
  output logic [NREQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]        rsp_rdata_o,
  output logic                     rsp_err_o,
  apb_rr_master_arbiter_if.master  apb
);

  localparam int PTR_W  = idx_w(NREQ);
  // Counter must be able to hold TIMEOUT itself.
  localparam int WAIT_W = clog2(TIMEOUT + 1);

  arb_state_e        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_owner;
  logic [WAIT_W-1:0] r_wait;

  logic              r_psel;
  logic              r_penable;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;

  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic [NREQ-1:0]   w_grant;
  logic [PTR_W-1:0]  w_idx;
  logic              w_any;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic              w_timeout;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req   (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Pointer moves just past the winner so it becomes lowest priority next.
  assign w_ptr_nxt = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + PTR_W'(1);

  // Current ACCESS cycle is the last allowed one.
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));

  // Requests are accepted only while idle; the strobe is the arbiter grant.
  assign req_ready_o = (r_state == IDLE) ? w_grant : '0;

  assign apb.psel_o    = r_psel;
  assign apb.penable_o = r_penable;
  assign apb.paddr_o   = r_paddr;
  assign apb.pwrite_o  = r_pwrite;
  assign apb.pwdata_o  = r_pwdata;

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_wait      <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // Response is a single-cycle pulse; data is zero whenever not valid.
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;

      case (r_state)
        IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (w_any) begin
            r_paddr   <= req_addr_i[int'(w_idx)*ADDR_W +: ADDR_W];
            r_pwdata  <= req_wdata_i[int'(w_idx)*DATA_W +: DATA_W];
            r_pwrite  <= req_write_i[w_idx];
            r_owner   <= w_idx;
            r_ptr     <= w_ptr_nxt;
            r_wait    <= '0;
            r_psel    <= 1'b1;
            r_state   <= SETUP;
          end
        end

        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end

        ACCESS: begin
          r_wait <= r_wait + WAIT_W'(1);
          // Ready is checked first so it wins over an expiring count.
          if (apb.pready_i) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_rdata          <= r_pwrite ? '0 : apb.prdata_i;
            r_psel               <= 1'b0;
            r_penable            <= 1'b0;
            r_state              <= IDLE;
          end else if (w_timeout) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_err            <= 1'b1;
            r_psel               <= 1'b0;
            r_penable            <= 1'b0;
            r_state              <= IDLE;
          end
        end

        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
module tb_apb_rr_master_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic             pclk = 1'b0;
  logic             preset;
  logic [NREQ-1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;

  logic             tb_auto, tb_pready;
  logic [DW-1:0]    tb_prdata;

  always #5 pclk = ~pclk;

  apb_rr_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) apb();

  // Slave model: fixed data, or address-derived data in auto mode.
  assign apb.pready_i = tb_pready;
  assign apb.prdata_i = tb_auto ? (apb.paddr_o ^ KEY) : tb_prdata;

  apb_rr_master_arbiter #(
    .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .apb         (apb)
  );

  typedef struct {
    logic [NREQ-1:0] onehot;
    logic            err;
    logic [DW-1:0]   rdata;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic test_reset();
    preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    tb_auto = 1'b0; tb_pready = 1'b0; tb_prdata = '0;
    repeat (3) @(negedge pclk);
    n_cmp++;
    if ({apb.psel_o, apb.penable_o, apb.pwrite_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got psel/penable/pwrite=%b, want 000", {apb.psel_o, apb.penable_o, apb.pwrite_o});
    end
    n_cmp++;
    if (apb.paddr_o !== '0 || apb.pwdata_o !== '0) begin
      n_err++; $display("FAIL reset_bus: got paddr=%h pwdata=%h, want 0/0", apb.paddr_o, apb.pwdata_o);
    end
    n_cmp++;
    if (rsp_valid !== '0 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
      n_err++; $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h, want 0", rsp_valid, rsp_err, rsp_rdata);
    end
    n_cmp++;
    if (req_ready !== '0) begin
      n_err++; $display("FAIL reset_ready: got %b, want 00", req_ready);
    end
    preset = 1'b0;
  endtask

  task automatic test_single_read();
    int n_psel, n_pen;
    bit got;
    exp_t e;
    n_psel = 0; n_pen = 0; got = 0;
    @(negedge pclk);
    req_valid = 2'b01; req_write = 2'b00; req_addr[0 +: AW] = 32'h10; tb_prdata = 32'h20;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL rd_accept: got ready=%b, want 01", req_ready);
    end
    sb.push_back('{2'b01, 1'b0, 32'h20, -1});
    for (int c = 1; c <= 6; c++) begin
      @(negedge pclk);
      req_valid = '0;
      if (apb.psel_o === 1'b1) begin
        n_psel++;
        n_cmp++;
        if (apb.paddr_o !== 32'h10 || apb.pwrite_o !== 1'b0) begin
          n_err++; $display("FAIL rd_addr: got paddr=%h pwrite=%b, want 10/0", apb.paddr_o, apb.pwrite_o);
        end
      end
      if (apb.penable_o === 1'b1) n_pen++;
      if (rsp_valid !== '0) begin
        got = 1;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rd_unexpected: got rsp_valid=%b, want none", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.onehot || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            n_err++; $display("FAIL rd_rsp: got valid=%b err=%b rdata=%h, want valid=%b err=%b rdata=%h",
                              rsp_valid, rsp_err, rsp_rdata, e.onehot, e.err, e.rdata);
          end
        end
      end
      // Ready is given in the second ACCESS cycle.
      tb_pready = (apb.psel_o === 1'b1 && apb.penable_o === 1'b1 && n_pen == 2);
    end
    tb_pready = 1'b0;
    n_cmp++;
    if (n_psel != 3 || n_pen != 2 || !got) begin
      n_err++; $display("FAIL rd_phases: got psel=%0d penable=%0d rsp=%0d cycles, want 3/2/1", n_psel, n_pen, got);
    end
  endtask

  task automatic test_single_write();
    int n_pen;
    bit got;
    exp_t e;
    n_pen = 0; got = 0;
    @(negedge pclk);
    req_valid = 2'b10; req_write = 2'b10;
    req_addr[AW +: AW] = 32'h04; req_wdata[DW +: DW] = 32'hDEADBEEF; tb_prdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL wr_accept: got ready=%b, want 10", req_ready);
    end
    sb.push_back('{2'b10, 1'b0, 32'h0, -1});
    for (int c = 1; c <= 6; c++) begin
      @(negedge pclk);
      req_valid = '0;
      req_wdata[DW +: DW] = 32'h0;
      if (apb.psel_o === 1'b1) begin
        n_cmp++;
        if (apb.pwrite_o !== 1'b1 || apb.pwdata_o !== 32'hDEADBEEF || apb.paddr_o !== 32'h04) begin
          n_err++; $display("FAIL wr_bus: got pwrite=%b pwdata=%h paddr=%h, want 1/DEADBEEF/04",
                            apb.pwrite_o, apb.pwdata_o, apb.paddr_o);
        end
      end
      if (apb.penable_o === 1'b1) n_pen++;
      if (rsp_valid !== '0) begin
        got = 1;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL wr_unexpected: got rsp_valid=%b, want none", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.onehot || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            n_err++; $display("FAIL wr_rsp: got valid=%b err=%b rdata=%h, want valid=%b err=%b rdata=%h",
                              rsp_valid, rsp_err, rsp_rdata, e.onehot, e.err, e.rdata);
          end
        end
      end
      tb_pready = (apb.psel_o === 1'b1 && apb.penable_o === 1'b1 && n_pen == 2);
    end
    tb_pready = 1'b0;
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL wr_done: got no response, want one");
    end
  endtask

  task automatic test_contention();
    int n_g, prev_g, g;
    exp_t e;
    n_g = 0; prev_g = -1;
    @(negedge pclk); preset = 1'b1;
    @(negedge pclk); preset = 1'b0;
    tb_auto = 1'b1; tb_pready = 1'b1;
    req_write = '0; req_addr[0 +: AW] = 32'h100; req_addr[AW +: AW] = 32'h200;
    req_valid = 2'b11;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge pclk);
      if (n_g == 4) req_valid = '0;
      #1;
      if (req_ready !== '0) begin
        g = (req_ready === 2'b10) ? 1 : 0;
        n_cmp++;
        if (req_ready !== (2'b01 << (n_g % 2)) || g == prev_g) begin
          n_err++; $display("FAIL cont_grant%0d: got ready=%b, want %b", n_g, req_ready, 2'b01 << (n_g % 2));
        end
        sb.push_back('{req_ready, 1'b0, req_addr[g*AW +: AW] ^ KEY, cyc + 3});
        prev_g = g; n_g++;
      end
      if (rsp_valid !== '0) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL cont_unexpected: got rsp_valid=%b, want none", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.onehot || rsp_err !== e.err || rsp_rdata !== e.rdata || cyc != e.cyc) begin
            n_err++; $display("FAIL cont_rsp: got valid=%b err=%b rdata=%h cyc=%0d, want valid=%b err=%b rdata=%h cyc=%0d",
                              rsp_valid, rsp_err, rsp_rdata, cyc, e.onehot, e.err, e.rdata, e.cyc);
          end
        end
      end
      if (n_g == 4 && sb.size() == 0) break;
    end
    n_cmp++;
    if (n_g != 4 || sb.size() != 0) begin
      n_err++; $display("FAIL cont_count: got %0d grants %0d pending, want 4/0", n_g, sb.size());
    end
  endtask

  task automatic test_timeout();
    int n_acc;
    bit got;
    exp_t e;
    n_acc = 0; got = 0;
    @(negedge pclk);
    tb_auto = 1'b0; tb_pready = 1'b0; tb_prdata = 32'hCAFE_F00D;
    req_valid = 2'b01; req_write = '0; req_addr[0 +: AW] = 32'h30;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL to_accept: got ready=%b, want 01", req_ready);
    end
    sb.push_back('{2'b01, 1'b1, 32'h0, -1});
    for (int c = 1; c < 40 && !got; c++) begin
      @(negedge pclk);
      req_valid = '0;
      if (apb.psel_o === 1'b1 && apb.penable_o === 1'b1) n_acc++;
      if (rsp_valid !== '0) begin
        got = 1;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL to_unexpected: got rsp_valid=%b, want none", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.onehot || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            n_err++; $display("FAIL to_rsp: got valid=%b err=%b rdata=%h, want valid=%b err=%b rdata=%h",
                              rsp_valid, rsp_err, rsp_rdata, e.onehot, e.err, e.rdata);
          end
        end
      end
    end
    n_cmp++;
    if (n_acc != TO || !got) begin
      n_err++; $display("FAIL to_cycles: got %0d ACCESS cycles rsp=%0d, want %0d/1", n_acc, got, TO);
    end
    // Following request must complete normally.
    got = 0;
    tb_pready = 1'b1; tb_auto = 1'b1;
    @(negedge pclk);
    req_valid = 2'b10; req_write = 2'b10; req_addr[AW +: AW] = 32'h44; req_wdata[DW +: DW] = 32'h1234;
    #1;
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL to_next_accept: got ready=%b, want 10", req_ready);
    end
    sb.push_back('{2'b10, 1'b0, 32'h0, cyc + 3});
    for (int c = 1; c < 8 && !got; c++) begin
      @(negedge pclk);
      req_valid = '0;
      if (rsp_valid !== '0) begin
        got = 1;
        n_cmp++;
        e = sb.pop_front();
        if (rsp_valid !== e.onehot || rsp_err !== e.err || rsp_rdata !== e.rdata || cyc != e.cyc) begin
          n_err++; $display("FAIL to_next_rsp: got valid=%b err=%b rdata=%h cyc=%0d, want valid=%b err=%b rdata=%h cyc=%0d",
                            rsp_valid, rsp_err, rsp_rdata, cyc, e.onehot, e.err, e.rdata, e.cyc);
        end
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL to_next_done: got no response, want one");
    end
  endtask

  task automatic test_reset_mid();
    bit got, bad;
    exp_t e;
    got = 0; bad = 0;
    @(negedge pclk);
    tb_auto = 1'b0; tb_pready = 1'b0;
    req_valid = 2'b01; req_write = '0; req_addr[0 +: AW] = 32'h50;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL rm_accept: got ready=%b, want 01", req_ready);
    end
    @(negedge pclk); req_valid = '0;
    @(negedge pclk);
    n_cmp++;
    if (apb.psel_o !== 1'b1 || apb.penable_o !== 1'b1) begin
      n_err++; $display("FAIL rm_access: got psel=%b penable=%b, want 1/1", apb.psel_o, apb.penable_o);
    end
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    n_cmp++;
    if (apb.psel_o !== 1'b0 || apb.penable_o !== 1'b0 || rsp_valid !== '0) begin
      n_err++; $display("FAIL rm_abort: got psel=%b penable=%b rsp_valid=%b, want 0/0/00",
                        apb.psel_o, apb.penable_o, rsp_valid);
    end
    repeat (3) begin
      @(negedge pclk);
      if (rsp_valid !== '0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL rm_no_rsp: got a response pulse after reset, want none");
    end
    tb_auto = 1'b1; tb_pready = 1'b1;
    req_valid = 2'b11; req_addr[AW +: AW] = 32'h60;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL rm_ptr: got ready=%b, want 01", req_ready);
    end
    sb.push_back('{2'b01, 1'b0, 32'h50 ^ KEY, cyc + 3});
    for (int c = 1; c < 8 && !got; c++) begin
      @(negedge pclk);
      req_valid = '0;
      if (rsp_valid !== '0) begin
        got = 1;
        n_cmp++;
        e = sb.pop_front();
        if (rsp_valid !== e.onehot || rsp_err !== e.err || rsp_rdata !== e.rdata || cyc != e.cyc) begin
          n_err++; $display("FAIL rm_rsp: got valid=%b err=%b rdata=%h cyc=%0d, want valid=%b err=%b rdata=%h cyc=%0d",
                            rsp_valid, rsp_err, rsp_rdata, cyc, e.onehot, e.err, e.rdata, e.cyc);
        end
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL rm_done: got no response, want one");
    end
  endtask

  task automatic test_back_to_back();
    int n_acc, last_acc;
    logic [AW-1:0] acc_addr;
    exp_t e;
    n_acc = 0; last_acc = -1; acc_addr = '0;
    tb_auto = 1'b1; tb_pready = 1'b1;
    req_write = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      req_valid = (c < 30) ? 2'b01 : 2'b00;
      req_addr[0 +: AW] = 32'h1000 + 32'(c * 4);
      #1;
      if (apb.psel_o === 1'b1) begin
        n_cmp++;
        if (apb.paddr_o !== acc_addr) begin
          n_err++; $display("FAIL b2b_paddr: got paddr=%h penable=%b, want %h", apb.paddr_o, apb.penable_o, acc_addr);
        end
      end
      if (req_ready !== '0) begin
        n_cmp++;
        if (req_ready !== 2'b01 || (last_acc >= 0 && cyc - last_acc != 3)) begin
          n_err++; $display("FAIL b2b_accept: got ready=%b gap=%0d, want 01/3", req_ready, cyc - last_acc);
        end
        last_acc = cyc;
        acc_addr = req_addr[0 +: AW];
        sb.push_back('{2'b01, 1'b0, req_addr[0 +: AW] ^ KEY, cyc + 3});
        n_acc++;
      end
      if (rsp_valid !== '0) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL b2b_unexpected: got rsp_valid=%b, want none", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.onehot || rsp_err !== e.err || rsp_rdata !== e.rdata || cyc != e.cyc) begin
            n_err++; $display("FAIL b2b_rsp: got valid=%b err=%b rdata=%h cyc=%0d, want valid=%b err=%b rdata=%h cyc=%0d",
                              rsp_valid, rsp_err, rsp_rdata, cyc, e.onehot, e.err, e.rdata, e.cyc);
          end
        end
      end
    end
    n_cmp++;
    if (n_acc != 10 || sb.size() != 0) begin
      n_err++; $display("FAIL b2b_count: got %0d accepts %0d pending, want 10/0", n_acc, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_drain: got %0d outstanding, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
